// File: rtl/truth_table_extractor_pkg.sv
// Shared types and helpers for the truth-table extractor: FSM state encoding,
// default parameter values and width helpers.
package tt_extract_pkg;

    localparam int unsigned DEF_N_INPUTS      = 3;
    localparam int unsigned DEF_SETTLE_CYCLES = 4;
    localparam int unsigned DEF_SAMPLES       = 3;
    localparam int unsigned DEF_SYNC_STAGES   = 2;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_e;

    function automatic int unsigned rows_of(input int unsigned n_inputs);
        return 32'd1 << n_inputs;
    endfunction

    // Width of a counter that runs 0..count-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned count);
        return (count < 2) ? 1 : $clog2(count);
    endfunction

endpackage

// File: rtl/truth_table_extractor_bit_sync.sv
// Multi-stage synchronizer bringing the characterized block's output into
// the clk domain; all stages reset asynchronously to 0.
module bit_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d[0] = d;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/truth_table_extractor.sv
// Sweeps every input vector of a combinational block, majority-votes its
// settled output per row and assembles the truth-table code (row 0 = MSB).
module truth_table_extractor
    import tt_extract_pkg::*;
#(
    parameter  int unsigned N_INPUTS      = DEF_N_INPUTS,
    parameter  int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter  int unsigned SAMPLES       = DEF_SAMPLES,
    parameter  int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
    localparam int unsigned ROWS          = rows_of(N_INPUTS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [ROWS-1:0]     expected_code,
    output logic [N_INPUTS-1:0] dut_in,
    input  logic                dut_out,
    output logic                busy,
    output logic                done,
    output logic [ROWS-1:0]     code,
    output logic                match
);

    localparam int unsigned RW = $clog2(ROWS + 1);
    localparam int unsigned SW = cnt_width(SETTLE_CYCLES);
    localparam int unsigned PW = cnt_width(SAMPLES);
    localparam int unsigned OW = $clog2(SAMPLES + 1);

    if (N_INPUTS < 1) begin : g_bad_inputs
        $error("truth_table_extractor: N_INPUTS must be >= 1");
    end
    if (SYNC_STAGES < 1) begin : g_bad_sync
        $error("truth_table_extractor: SYNC_STAGES must be >= 1");
    end
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES < SYNC_STAGES) begin : g_bad_settle
        $error("truth_table_extractor: SETTLE_CYCLES must be >= 1 and >= SYNC_STAGES");
    end
    if (SAMPLES < 1 || (SAMPLES % 2) == 0) begin : g_bad_samples
        $error("truth_table_extractor: SAMPLES must be odd and >= 1");
    end

    state_e          state_q,  state_d;
    logic [RW-1:0]   row_q,    row_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic [PW-1:0]   sample_q, sample_d;
    logic [OW-1:0]   ones_q,   ones_d;
    logic [ROWS-1:0] code_q,   code_d;
    logic [ROWS-1:0] exp_q,    exp_d;
    logic            match_q,  match_d;
    logic [OW-1:0]   vote;
    logic            sync_out;

    bit_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (dut_out),
        .q    (sync_out)
    );

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        settle_d = settle_q;
        sample_d = sample_q;
        ones_d   = ones_q;
        code_d   = code_q;
        exp_d    = exp_q;
        match_d  = match_q;
        vote     = ones_q + OW'(sync_out);

        if (abort && state_q != IDLE) begin
            // Partial code is kept for debug; only match is withdrawn.
            state_d  = IDLE;
            row_d    = '0;
            settle_d = '0;
            sample_d = '0;
            ones_d   = '0;
            match_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        exp_d    = expected_code;
                        code_d   = '0;
                        match_d  = 1'b0;
                        row_d    = '0;
                        settle_d = '0;
                        sample_d = '0;
                        ones_d   = '0;
                        state_d  = SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                        settle_d = '0;
                        state_d  = SAMPLE;
                    end else begin
                        settle_d = settle_q + SW'(1);
                    end
                end
                SAMPLE: begin
                    if (sample_q == PW'(SAMPLES - 1)) begin
                        for (int unsigned i = 0; i < ROWS; i++) begin
                            if (row_q == RW'(ROWS - 1 - i)) begin
                                code_d[i] = (vote > OW'(SAMPLES / 2));
                            end
                        end
                        sample_d = '0;
                        ones_d   = '0;
                        if (row_q == RW'(ROWS - 1)) begin
                            match_d = (code_d == exp_q);
                            state_d = DONE;
                        end else begin
                            row_d   = row_q + RW'(1);
                            state_d = SETTLE;
                        end
                    end else begin
                        ones_d   = vote;
                        sample_d = sample_q + PW'(1);
                    end
                end
                DONE: begin
                    row_d   = '0;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            row_q    <= '0;
            settle_q <= '0;
            sample_q <= '0;
            ones_q   <= '0;
            code_q   <= '0;
            exp_q    <= '0;
            match_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            settle_q <= settle_d;
            sample_q <= sample_d;
            ones_q   <= ones_d;
            code_q   <= code_d;
            exp_q    <= exp_d;
            match_q  <= match_d;
        end
    end

    assign busy   = (state_q == SETTLE) || (state_q == SAMPLE);
    assign done   = (state_q == DONE);
    assign dut_in = busy ? row_q[N_INPUTS-1:0] : '0;
    assign code   = code_q;
    assign match  = match_q;

endmodule

// File: tb/tb_truth_table_extractor.sv
// Directed self-checking bench for truth_table_extractor with default
// parameters; the characterized block is modelled inline.
module tb_truth_table_extractor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] expected_code;
    logic [2:0] dut_in;
    logic       dut_out;
    logic       busy;
    logic       done;
    logic [7:0] code;
    logic       match;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // 0 = function 0xA7, 1 = tied low, 2 = tied high
    int unsigned mode = 0;
    logic        glitch = 1'b0;
    logic        model_out;

    always #5 clk = ~clk;

    always_comb begin
        model_out = 1'b0;
        case (mode)
            0: model_out = !((dut_in[0] & !dut_in[2]) | (dut_in[2] & !dut_in[1] & !dut_in[0]));
            1: model_out = 1'b0;
            default: model_out = 1'b1;
        endcase
        dut_out = model_out ^ glitch;
    end

    truth_table_extractor u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .expected_code(expected_code),
        .dut_in       (dut_in),
        .dut_out      (dut_out),
        .busy         (busy),
        .done         (done),
        .code         (code),
        .match        (match)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full sweep; start is sampled at the edge ending cycle T, checks run in T+1..T+58.
    task automatic run_sweep(input logic [7:0] exp_code, input bit glitch_en, input bit repulse,
                             input logic [7:0] want_code, input bit want_match);
        bit busy_ok = 1'b1;
        bit din_ok  = 1'b1;
        bit done_ok = 1'b1;
        expected_code = exp_code;
        start = 1'b1;
        tick();
        start = 1'b0;
        expected_code = ~exp_code;
        for (int k = 1; k <= 56; k++) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (dut_in !== 3'((k - 1) / 7)) din_ok = 1'b0;
            if (done !== 1'b0) done_ok = 1'b0;
            glitch = glitch_en && (k >= 4) && (((k - 4) % 7) == 0);
            start  = repulse && (k == 10 || k == 53);
            tick();
        end
        glitch = 1'b0;
        start  = 1'b0;
        check_eq("sweep_busy_high", 32'(busy_ok), 32'd1);
        check_eq("sweep_dut_in_steps", 32'(din_ok), 32'd1);
        check_eq("sweep_no_early_done", 32'(done_ok), 32'd1);
        check_eq("done_at_T57", 32'(done), 32'd1);
        check_eq("busy_low_in_done", 32'(busy), 32'd0);
        check_eq("dut_in_zero_in_done", 32'(dut_in), 32'd0);
        check_eq("code_at_done", 32'(code), 32'(want_code));
        check_eq("match_at_done", 32'(match), 32'(want_match));
        tick();
        check_eq("done_one_cycle", 32'(done), 32'd0);
        check_eq("code_held", 32'(code), 32'(want_code));
        check_eq("match_held", 32'(match), 32'(want_match));
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        expected_code = 8'h00;
        #1;
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        check_eq("reset_dut_in", 32'(dut_in), 32'd0);
        check_eq("reset_code", 32'(code), 32'd0);
        check_eq("reset_match", 32'(match), 32'd0);
        #20;
        rst_n = 1'b1;
        tick();
        tick();

        mode = 0;
        run_sweep(8'hA7, 1'b0, 1'b0, 8'hA7, 1'b1);
        mode = 1;
        run_sweep(8'h01, 1'b0, 1'b0, 8'h00, 1'b0);
        mode = 2;
        run_sweep(8'h01, 1'b0, 1'b0, 8'hFF, 1'b0);
        mode = 0;
        run_sweep(8'hA7, 1'b1, 1'b0, 8'hA7, 1'b1);

        // Abort during row 4 SAMPLE (cycles T+33..T+35).
        expected_code = 8'hA7;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (33) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_dut_in", 32'(dut_in), 32'd0);
        check_eq("abort_no_done", 32'(done), 32'd0);
        check_eq("abort_match", 32'(match), 32'd0);
        check_eq("abort_partial_code", 32'(code), 32'hA0);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (done || busy) seen = 1'b1;
            tick();
        end
        check_eq("abort_stays_idle", 32'(seen), 32'd0);
        run_sweep(8'hA7, 1'b0, 1'b0, 8'hA7, 1'b1);

        // Restart attempts while busy are ignored.
        run_sweep(8'h5C, 1'b0, 1'b1, 8'hA7, 1'b0);

        // start together with abort in IDLE: abort wins.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done || busy || dut_in != 3'd0) seen = 1'b1;
            tick();
        end
        check_eq("start_abort_idle", 32'(seen), 32'd0);
        check_eq("start_abort_code_kept", 32'(code), 32'hA7);

        // Asynchronous reset mid-SETTLE of row 2 (cycles T+15..T+18).
        expected_code = 8'hA7;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (15) tick();
        check_eq("pre_reset_dut_in", 32'(dut_in), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_dut_in", 32'(dut_in), 32'd0);
        check_eq("arst_done", 32'(done), 32'd0);
        check_eq("arst_code", 32'(code), 32'd0);
        check_eq("arst_match", 32'(match), 32'd0);
        #3;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done || busy || dut_in != 3'd0) seen = 1'b1;
        end
        check_eq("post_reset_idle", 32'(seen), 32'd0);
        run_sweep(8'hA7, 1'b0, 1'b0, 8'hA7, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/truth_table_extractor.md
Name: truth_table_extractor

Overview:
- Sequential characterizer for combinational logic blocks, 3 inputs by default.
- Sweeps all 2^N input vectors on `dut_in`, waits for settle, then samples `dut_out` with majority voting.
- Assembles the circuit's truth-table code; the same 0xA7-style hex code names each design in our gate-library flow.
- Used in benches and on-chip self-test to read back a synthesized netlist's function and compare it to its intended code.

Parameters:
- N_INPUTS, 3: number of DUT inputs; ROWS = 2^N_INPUTS.
- SETTLE_CYCLES, 4: cycles each vector is held before sampling; must be >= 1 and >= SYNC_STAGES.
- SAMPLES, 3: samples per row; odd, >= 1; majority vote.
- SYNC_STAGES, 2: flops on `dut_out` before use; >= 1.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin sweep; honoured only in IDLE.
- abort  input  1  cancel sweep; returns to IDLE, no `done`.
- expected_code  input  ROWS  intended truth-table code; captured at start.
- dut_in  output  N_INPUTS  vector driven to DUT; dut_in[N-1] is the row MSB (in1,in2,in3 for N=3).
- dut_out  input  1  DUT output; asynchronous to vector changes.
- busy  output  1  high in SETTLE/SAMPLE.
- done  output  1  one-cycle pulse; `code` and `match` valid.
- code  output  ROWS  extracted truth table.
- match  output  1  code == captured expected_code.

Behaviour:
- Reset: state IDLE; dut_in=0, busy=0, done=0, code=0, match=0; row, settle, sample and vote counters =0; sync flops =0.
- Reset is fully asynchronous and may occur mid-sweep. All outputs return to reset values; no partial `done`.
- Bit order: row r = dut_in value; code[ROWS-1-r] = output for row r, so row 0 is the MSB.
  - Check: in1=A, in2=B, in3=C; out = NOT((C AND NOT A) OR (A AND NOT B AND NOT C)) gives 0xA7.
- State IDLE, start sampled high at cycle T: capture expected_code, clear code and match, row=0, go to SETTLE.
- State SETTLE, cycles T+1..T+SETTLE_CYCLES: dut_in=row; counter counts SETTLE_CYCLES cycles; then go to SAMPLE. busy=1.
- State SAMPLE, SAMPLES cycles:
  - Each cycle add the synchronized dut_out to the ones-count.
  - On the last sample, bit = (ones-count including this sample) > SAMPLES/2. Write code[ROWS-1-row] and clear the count.
  - If row == ROWS-1, go to DONE; else row+1 and go to SETTLE.
  - dut_in stays stable throughout SAMPLE.
- State DONE:
  - Reached at cycle T + ROWS*(SETTLE_CYCLES+SAMPLES) + 1; this is 57 for defaults.
  - done=1 for exactly that cycle; match=(code==captured expected) in the same cycle; dut_in=0.
  - Next cycle: IDLE.
- code and match hold their values until the next accepted start.
- start while busy or in DONE: ignored.
- abort has priority over start and over state progression, in SETTLE/SAMPLE/DONE. Next cycle: IDLE, dut_in=0, busy=0, done not pulsed. code keeps its partial contents; match=0.
- Simultaneous start and abort in IDLE: abort wins, start ignored.
- Row counter is ceil-log width of ROWS+1; no wrap, because the sweep ends at ROWS-1.
- Vote counter width is clog2(SAMPLES+1).
- Synchronizer latency is covered by SETTLE_CYCLES >= SYNC_STAGES. Elaboration asserts the parameter constraints.

Decomposition:
- Package `tt_extract_pkg`: state enum {IDLE, SETTLE, SAMPLE, DONE}; ROWS / clog2 helper functions; default parameter constants.
- Sub-module `bit_sync`: SYNC_STAGES-deep synchronizer for dut_out, async active-low reset to 0.
- FSM, counters and code assembly stay in the top.

Test Plan:
- DUT model of function 0xA7 (defaults), expected_code=0xA7, start pulse at T -> dut_in steps 0..7 every 7 cycles; done at T+57 with code=0xA7, match=1; busy high T+1..T+56.
- DUT tied 0, expected_code=0x01 -> code=0x00, match=0; DUT tied 1 -> code=0xFF.
- 0xA7 model with a single-cycle inverted glitch in one sample of each row (SAMPLES=3) -> code still 0xA7.
- abort during row 4 SAMPLE -> next cycle IDLE, dut_in=0, no done pulse, match=0; a new start then yields the full correct code.
- start re-pulsed while busy, and simultaneous start+abort in IDLE -> no restart, done only at T+57; IDLE stays idle.
- rst_n dropped asynchronously mid-SETTLE of row 2 -> all outputs 0 immediately; after release, IDLE until start.
